// File: rtl/i2c_write_sequencer.sv
// Purpose : command/payload front end for the I2C byte master; runs START, addr+W, N data bytes, STOP.
// Latency : START is driven the cycle after a command is accepted; each step then waits one master ready low/high handshake.
// Backpressure: cmd_ready only in IDLE with the master ready; wdata_ready drops when the payload FIFO is full; a watchdog aborts stalls.
//
// Ports
//   clk, reset         : clock, synchronous active-low reset
//   cmd_valid/ready    : write command handshake carrying cmd_addr (7b) and cmd_len (0..DEPTH, larger values clipped)
//   wdata_valid/ready  : payload byte push into the internal FIFO
//   busy, done         : transfer in progress / one-cycle pulse on clean STOP completion
//   err_timeout        : one-cycle pulse when the watchdog aborts a transfer
//   bytes_sent         : payload bytes acknowledged by m_tx_done in the current or last transfer
//   m_i2c_en/start/stop, m_tx_data : registered command pattern towards the byte master
//   m_ready, m_tx_done : master handshake and byte-shifted pulse

module i2c_write_sequencer #(
   parameter int DEPTH          = 4,       // power of 2, >= 2
   parameter int LEN_W          = 3,       // must be able to hold the value DEPTH
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [6:0]       cmd_addr,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic             wdata_valid,
   output logic             wdata_ready,
   input  logic [7:0]       wdata,
   output logic             busy,
   output logic             done,
   output logic             err_timeout,
   output logic [LEN_W:0]   bytes_sent,
   output logic             m_i2c_en,
   output logic             m_i2c_start,
   output logic             m_i2c_stop,
   output logic [7:0]       m_tx_data,
   input  logic             m_ready,
   input  logic             m_tx_done
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_ISSUE_START,
      S_ISSUE_ADDR,
      S_DATA_CHK,
      S_ISSUE_DATA,
      S_ISSUE_STOP,
      S_WAIT_LO,
      S_WAIT_HI,
      S_FINISH
   } state_t;

   state_t           state_q;
   state_t           ret_q;         // where to go once the ready low/high handshake completes
   logic [6:0]       addr_q;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] issued_q;      // data bytes handed to the master so far
   logic [LEN_W:0]   bytes_sent_q;
   logic             addr_sent_q;   // address byte finished; m_tx_done now counts payload
   logic             timed_out_q;   // DATA_CHK stall forced the STOP
   logic [WD_W-1:0]  wd_q;
   logic             busy_q;
   logic             done_q;
   logic             err_q;
   logic             m_en_q;
   logic             m_start_q;
   logic             m_stop_q;
   logic [7:0]       m_tx_data_q;

   // payload FIFO
   logic [7:0]       mem_q [DEPTH];
   logic [PTR_W-1:0] wr_q;
   logic [PTR_W-1:0] rd_q;
   logic [CNT_W-1:0] cnt_q;

   logic             fifo_empty;
   logic             fifo_push;
   logic             fifo_pop;
   logic             fifo_flush;
   logic             wd_hit;
   logic             wait_abort;
   logic [LEN_W-1:0] len_d;

   assign fifo_empty  = (cnt_q == '0);
   assign wdata_ready = (cnt_q != CNT_W'(DEPTH));
   assign fifo_push   = wdata_valid && wdata_ready;
   assign cmd_ready   = (state_q == S_IDLE) && m_ready;

   assign len_d  = (cmd_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : cmd_len;
   assign wd_hit = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

   // Pop happens on the same edge the FSM leaves DATA_CHK for ISSUE_DATA.
   assign fifo_pop = (state_q == S_DATA_CHK) && (issued_q != len_q) && !fifo_empty;

   // Master stuck mid-handshake: leave without STOP.
   assign wait_abort = wd_hit &&
                       (((state_q == S_WAIT_LO) && m_ready) ||
                        ((state_q == S_WAIT_HI) && !m_ready));

   // Any abort discards leftover payload; a push landing on the flush edge is dropped too.
   assign fifo_flush = wait_abort || ((state_q == S_FINISH) && timed_out_q);

   always_ff @(posedge clk) begin
      if (reset && fifo_push && !fifo_flush) begin
         mem_q[wr_q] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset || fifo_flush) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (fifo_push) begin
            wr_q <= wr_q + PTR_W'(1);
         end
         if (fifo_pop) begin
            rd_q <= rd_q + PTR_W'(1);
         end
         case ({fifo_push, fifo_pop})
            2'b10:   cnt_q <= cnt_q + CNT_W'(1);
            2'b01:   cnt_q <= cnt_q - CNT_W'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Sequencer: m_* patterns are loaded on the edge that enters an ISSUE state
   // and cleared on the edge that leaves it, so each pattern lasts one cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         ret_q        <= S_IDLE;
         addr_q       <= '0;
         len_q        <= '0;
         issued_q     <= '0;
         bytes_sent_q <= '0;
         addr_sent_q  <= 1'b0;
         timed_out_q  <= 1'b0;
         wd_q         <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         m_en_q       <= 1'b0;
         m_start_q    <= 1'b0;
         m_stop_q     <= 1'b0;
         m_tx_data_q  <= '0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;

         if (addr_sent_q && m_tx_done && (bytes_sent_q < {1'b0, len_q})) begin
            bytes_sent_q <= bytes_sent_q + (LEN_W+1)'(1);
         end

         case (state_q)
            S_IDLE: begin
               wd_q <= '0;
               if (cmd_valid && cmd_ready) begin
                  addr_q       <= cmd_addr;
                  len_q        <= len_d;
                  issued_q     <= '0;
                  bytes_sent_q <= '0;
                  addr_sent_q  <= 1'b0;
                  timed_out_q  <= 1'b0;
                  busy_q       <= 1'b1;
                  m_en_q       <= 1'b1;
                  m_start_q    <= 1'b1;
                  state_q      <= S_ISSUE_START;
               end
            end

            S_ISSUE_START: begin
               m_en_q    <= 1'b0;
               m_start_q <= 1'b0;
               ret_q     <= S_ISSUE_ADDR;
               state_q   <= S_WAIT_LO;
            end

            S_ISSUE_ADDR, S_ISSUE_DATA: begin
               m_en_q  <= 1'b0;
               ret_q   <= S_DATA_CHK;
               state_q <= S_WAIT_LO;
            end

            S_ISSUE_STOP: begin
               m_en_q   <= 1'b0;
               m_stop_q <= 1'b0;
               ret_q    <= S_FINISH;
               state_q  <= S_WAIT_LO;
            end

            S_WAIT_LO: begin
               if (!m_ready) begin
                  wd_q    <= '0;
                  state_q <= S_WAIT_HI;
               end else if (wait_abort) begin
                  wd_q        <= '0;
                  err_q       <= 1'b1;
                  busy_q      <= 1'b0;
                  addr_sent_q <= 1'b0;
                  state_q     <= S_IDLE;
               end else begin
                  wd_q <= wd_q + WD_W'(1);
               end
            end

            S_WAIT_HI: begin
               if (m_ready) begin
                  wd_q <= '0;
                  case (ret_q)
                     S_ISSUE_ADDR: begin
                        m_en_q      <= 1'b1;
                        m_tx_data_q <= {addr_q, 1'b0};
                        state_q     <= S_ISSUE_ADDR;
                     end
                     S_DATA_CHK: begin
                        addr_sent_q <= 1'b1;
                        state_q     <= S_DATA_CHK;
                     end
                     default: begin
                        state_q <= S_FINISH;
                     end
                  endcase
               end else if (wait_abort) begin
                  wd_q        <= '0;
                  err_q       <= 1'b1;
                  busy_q      <= 1'b0;
                  addr_sent_q <= 1'b0;
                  state_q     <= S_IDLE;
               end else begin
                  wd_q <= wd_q + WD_W'(1);
               end
            end

            S_DATA_CHK: begin
               if (issued_q == len_q) begin
                  wd_q     <= '0;
                  m_en_q   <= 1'b1;
                  m_stop_q <= 1'b1;
                  state_q  <= S_ISSUE_STOP;
               end else if (fifo_pop) begin
                  wd_q        <= '0;
                  m_en_q      <= 1'b1;
                  m_tx_data_q <= mem_q[rd_q];
                  issued_q    <= issued_q + LEN_W'(1);
                  state_q     <= S_ISSUE_DATA;
               end else if (wd_hit) begin
                  // Payload never arrived: close the bus cleanly, report as error.
                  wd_q        <= '0;
                  timed_out_q <= 1'b1;
                  m_en_q      <= 1'b1;
                  m_stop_q    <= 1'b1;
                  state_q     <= S_ISSUE_STOP;
               end else begin
                  wd_q <= wd_q + WD_W'(1);
               end
            end

            S_FINISH: begin
               wd_q        <= '0;
               done_q      <= !timed_out_q;
               err_q       <= timed_out_q;
               busy_q      <= 1'b0;
               addr_sent_q <= 1'b0;
               state_q     <= S_IDLE;
            end

            default: begin
               wd_q    <= '0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign err_timeout = err_q;
   assign bytes_sent  = bytes_sent_q;
   assign m_i2c_en    = m_en_q;
   assign m_i2c_start = m_start_q;
   assign m_i2c_stop  = m_stop_q;
   assign m_tx_data   = m_tx_data_q;

endmodule
